// File: rtl/immgen_pkg.sv
// rtl/immgen_pkg.sv - shared opcodes, FSM states and owner-id type for the immediate-decoder arbiter
//
// Purpose: common definitions imported by imm_decode and immgen_arbiter.
// Ports:   none (package).
package immgen_pkg;

  // Base-ISA major opcodes, instr[6:0]
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 values of the OP-IMM shifts whose immediate is a 5-bit shamt
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  // Largest supported core count; the owner id is sized to cover it so the
  // type is shared by every instance regardless of NUM_REQ.
  localparam int MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extractor for one instruction word
//
// Purpose: derive the immediate of a base-ISA instruction from its opcode.
// Ports:
//   instr  in   XLEN  instruction word
//   imm    out  XLEN  decoded immediate (0 for unsupported opcodes)
//   err    out  1     high when the opcode carries no supported immediate
module imm_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (opcode)
      OP_IMM: begin
        // Shift-immediates carry an unsigned shamt, not a signed imm12
        if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI)
          imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        else
          imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_LOAD, OP_JALR:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = XLEN'({instr[31:12], 12'b0});
      OP_JAL:
        imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
               instr[30:21], 1'b0};
      default:
        err = 1'b1;
    endcase
  end

endmodule

// File: rtl/immgen_arbiter.sv
// rtl/immgen_arbiter.sv - round-robin arbiter sharing one immediate decoder among NUM_REQ cores
//
// Purpose: grant one requesting core at a time, decode its instruction in a
//          single CALC cycle and hold the response until the owner accepts it.
// Ports:
//   clk        in   1             clock, rising edge
//   reset      in   1             asynchronous active-high reset
//   req_valid  in   NUM_REQ       per-core request valid
//   req_instr  in   NUM_REQ*XLEN  per-core instruction, core i at [i*XLEN +: XLEN]
//   req_ready  out  NUM_REQ       one-hot grant (combinational, IDLE only)
//   rsp_valid  out  NUM_REQ       one-hot response valid for the owner
//   rsp_ready  in   NUM_REQ       per-core response accept
//   rsp_imm    out  XLEN          decoded immediate
//   rsp_err    out  1             unsupported opcode flag
module immgen_arbiter
  import immgen_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_instr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_imm,
  output logic                    rsp_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t          state;
  owner_t          owner;
  owner_t          last_grant;
  logic [XLEN-1:0] instr_q;

  logic [XLEN-1:0] instr_arr [NUM_REQ];
  logic            grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [XLEN-1:0] grant_instr;
  int              cand;

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign instr_arr[i] = req_instr[i*XLEN +: XLEN];
  end

  // Round-robin search starting one past the previous winner
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_instr = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
        grant_instr = instr_arr[cand[IDX_W-1:0]];
      end
    end
  end

  // Gated by reset so a held request cannot see a grant while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found && !reset)
      req_ready[grant_idx] = 1'b1;
  end

  imm_decode #(
    .XLEN (XLEN)
  ) u_imm_decode (
    .instr (instr_q),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= owner_t'(NUM_REQ - 1);
      instr_q    <= '0;
      rsp_valid  <= '0;
      rsp_imm    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            instr_q    <= grant_instr;
            owner      <= owner_t'(grant_idx);
            last_grant <= owner_t'(grant_idx);
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_imm   <= dec_imm;
          rsp_err   <= dec_err;
          rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's accept counts; imm/err keep their value afterwards
          if (rsp_ready[owner[IDX_W-1:0]]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_immgen_arbiter.sv
// tb/tb_immgen_arbiter.sv - directed self-checking bench for immgen_arbiter
module tb_immgen_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*XLEN-1:0] req_instr;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [XLEN-1:0]         rsp_imm;
  logic                    rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] dec_in  [7] = '{32'hFFF00093, 32'h00509093, 32'h0020A423, 32'hFE000EE3,
                               32'h123450B7, 32'h001000EF, 32'h0000007F};
  logic [31:0] dec_exp [7] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000008, 32'hFFFFFFFC,
                               32'h12345000, 32'h00000800, 32'h00000000};
  logic        dec_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  immgen_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_instr (req_instr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_imm   (rsp_imm),
    .rsp_err   (rsp_err)
  );

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_instr = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_imm !== 32'h0) begin errors++; $display("FAIL reset_rsp_imm: got %h expected 00000000", rsp_imm); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b01;
      req_instr = {32'h0, dec_in[i]};
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL dec%0d_grant: got %b expected 01", i, req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      req_instr = {32'h0, 32'hDEADBEEF};
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL dec%0d_calc_valid: got %b expected 00", i, rsp_valid); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL dec%0d_rsp_valid: got %b expected 01", i, rsp_valid); end
      checks++; if (rsp_imm !== dec_exp[i]) begin errors++; $display("FAIL dec%0d_imm: got %h expected %h", i, rsp_imm, dec_exp[i]); end
      checks++; if (rsp_err !== dec_err[i]) begin errors++; $display("FAIL dec%0d_err: got %b expected %b", i, rsp_err, dec_err[i]); end
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL dec%0d_done: got %b expected 00", i, rsp_valid); end
    end
  endtask

  task automatic test_hold();
    req_valid = 2'b10;
    req_instr = {32'h123450B7, 32'h0};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_grant: got %b expected 10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL hold_valid_c%0d: got %b expected 10", k, rsp_valid); end
      checks++; if (rsp_imm !== 32'h12345000) begin errors++; $display("FAIL hold_imm_c%0d: got %h expected 12345000", k, rsp_imm); end
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 2'b10;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL hold_valid_c5: got %b expected 10", rsp_valid); end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL hold_idle_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_imm !== 32'h12345000) begin errors++; $display("FAIL hold_idle_imm: got %h expected 12345000", rsp_imm); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_oh;
    logic [31:0] exp_imm;
    req_valid = 2'b11;
    req_instr = {32'hFFF00093, 32'h00509093};
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_imm = (i % 2 == 0) ? 32'h00000005 : 32'hFFFFFFFF;
      #1;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL b2b%0d_grant: got %b expected %b", i, req_ready, exp_oh); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL b2b%0d_calc_ready: got %b expected 00", i, req_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL b2b%0d_rsp_valid: got %b expected %b", i, rsp_valid, exp_oh); end
      checks++; if (rsp_imm !== exp_imm) begin errors++; $display("FAIL b2b%0d_imm: got %h expected %h", i, rsp_imm, exp_imm); end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_calc();
    req_valid = 2'b01;
    req_instr = {32'h0, 32'h0020A423};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_pre_grant: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    reset     = 1'b1;
    req_valid = 2'b11;
    req_instr = {32'h0020A423, 32'h001000EF};
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_imm !== 32'h0) begin errors++; $display("FAIL rst_rsp_imm: got %h expected 00000000", rsp_imm); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_post_grant: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rst_post_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_imm !== 32'h00000800) begin errors++; $display("FAIL rst_post_imm: got %h expected 00000800", rsp_imm); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_post_err: got %b expected 0", rsp_err); end
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_post_done: got %b expected 00", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_hold();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/immgen_arbiter.md
IMMGEN_ARBITER -- requirements
Module: immgen_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of requesting cores sharing one immediate decoder (2..8).
REQ-002 Parameter XLEN, 32, instruction and immediate width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-core request valid.
REQ-006 req_instr  input  NUM_REQ*XLEN  per-core instruction word; core i occupies bits [i*XLEN +: XLEN].
REQ-007 req_ready  output  NUM_REQ  per-core request accept; at most one bit high per cycle.
REQ-008 rsp_valid  output  NUM_REQ  per-core response valid; at most one bit high per cycle.
REQ-009 rsp_ready  input  NUM_REQ  per-core response accept.
REQ-010 rsp_imm  output  XLEN  decoded immediate for the core whose rsp_valid is high.
REQ-011 rsp_err  output  1  high with rsp_valid when the opcode is unsupported.

Function
REQ-012 FSM states: IDLE, CALC, RESP.
- IDLE: if any req_valid, grant one core.
- CALC: lasts exactly one cycle.
- RESP: wait for rsp_ready of the owner.
REQ-013 IDLE grant: req_ready[g] is driven combinationally high in the same cycle for the granted core g only.
- Capture req_instr[g] and owner id g; move to CALC.
- req_ready is low in CALC and RESP.
REQ-014 Arbitration is round-robin.
- Search starts at (last_grant+1) mod NUM_REQ.
- last_grant updates only on a grant.
- last_grant resets to NUM_REQ-1, so core 0 wins first.
REQ-015 CALC: decode the captured instruction; register the result into rsp_imm and rsp_err; move to RESP.
REQ-016 RESP:
- rsp_valid[owner]=1; rsp_imm and rsp_err held stable.
- Move to IDLE on rsp_ready[owner]; rsp_ready of non-owners is ignored.
- No new grant in the same cycle, so minimum request-to-request spacing is 3 cycles.
REQ-017 Latency: the grant cycle is cycle 0; rsp_valid is first high in cycle 2.
REQ-018 Requesters hold req_valid and req_instr until req_ready.
- Dropping req_valid before grant withdraws the request without error.
- Instruction changes after grant do not affect the response.
REQ-019 Decode rules by opcode [6:0]:
- 0010011 with funct3 001/101: zero-extend [24:20].
- 0010011 otherwise, 0000011, 1100111: sign-extend [31:20].
- 0100011: sign-extend {[31:25],[11:7]}.
- 1100011: sign-extend {[31],[7],[30:25],[11:8],0}.
- 0110111, 0010111: {[31:12],12'b0}.
- 1101111: sign-extend {[31],[19:12],[20],[30:21],0}.
REQ-020 Any other opcode gives rsp_imm=0 and rsp_err=1; a supported opcode gives rsp_err=0.
REQ-021 rsp_imm and rsp_err are don't-care-free: they hold their last value outside RESP.

Reset
REQ-022 Reset asserted in any state, including mid-CALC or mid-RESP, immediately forces:
- state=IDLE, req_ready=0, rsp_valid=0, rsp_imm=0, rsp_err=0, last_grant=NUM_REQ-1.
- The in-flight transaction is discarded and not replayed.
REQ-023 The first grant is possible in the first clock edge after reset deasserts.

Structure
REQ-024 Shared package immgen_pkg holds:
- opcode localparams;
- the FSM state enum;
- the owner-id type (clog2 of NUM_REQ).
REQ-025 Decode is one combinational sub-module, imm_decode (instr in; imm and err out).
- It is instantiated once and shared by all cores.

Verification
REQ-026 Single decodes from core 0, each followed by rsp_ready -> required responses:
- 0xFFF00093 -> 0xFFFFFFFF.
- 0x00509093 -> 0x00000005.
- 0x0020A423 -> 0x00000008.
- 0xFE000EE3 -> 0xFFFFFFFC.
- 0x123450B7 -> 0x12345000.
- 0x001000EF -> 0x00000800.
- All with rsp_err=0.
REQ-027 0x0000007F (unsupported opcode) -> rsp_imm=0, rsp_err=1.
REQ-028 Both cores hold req_valid continuously with rsp_ready=1 -> grants 0,1,0,1,...; each response appears only on the owner's rsp_valid bit.
REQ-029 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_imm stable throughout; accepted on the 6th cycle; IDLE next.
REQ-030 Reset asserted during CALC -> all outputs 0 with no clock edge needed; the next request after release is granted to core 0 with the correct response.
